// File: rtl/cgra_power_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cgra_power_ctrl_pkg
//   Shared types and helpers for the CGRA power-sequencing controller.
//   - pwr_state_e      : sequencing FSM states (3-bit encoding)
//   - pwr_out_t        : bundle of the registered sequencing outputs
//   - DEF_*            : default parameter values for the controller
//   - outst_cnt_width  : width of a per-master outstanding-transaction counter
//   - timer_width      : width of the shared phase timer
// ----------------------------------------------------------------------------
package cgra_power_ctrl_pkg;

    typedef enum logic [2:0] {
        PWR_RESET = 3'd0,
        PWR_ON    = 3'd1,
        PWR_DRAIN = 3'd2,
        PWR_GATE  = 3'd3,
        PWR_OFF   = 3'd4,
        PWR_WAKE  = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic ack;     // switch acknowledge to the power manager
        logic hold;    // mask new CGRA OBI requests
        logic enable;  // CGRA clock-gate enable
        logic rst_n;   // CGRA logic reset, active low
    } pwr_out_t;

    // Output values held while the controller is in (or being forced into) RESET.
    localparam pwr_out_t OUT_RESET = '{ack: 1'b0, hold: 1'b1, enable: 1'b1, rst_n: 1'b0};

    localparam int unsigned DEF_N_MASTER      = 2;
    localparam int unsigned DEF_MAX_OUTST     = 4;
    localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;
    localparam int unsigned DEF_ACK_DELAY     = 4;
    localparam int unsigned DEF_PWRUP_DELAY   = 8;
    localparam int unsigned DEF_RST_CYCLES    = 16;

    // Counter must represent 0..max_outst inclusive.
    function automatic int unsigned outst_cnt_width(input int unsigned max_outst);
        return $clog2(max_outst + 1);
    endfunction

    // The phase timer counts 0..(longest delay - 1), so it needs clog2(longest) bits.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c,
                                                input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/cgra_obi_outst_cnt.sv
// ----------------------------------------------------------------------------
// cgra_obi_outst_cnt
//   Outstanding-transaction counter for one OBI master port.
//   Counts up on an accepted request, down on a response; a simultaneous
//   request and response cancel out. Saturates at MAX_OUTST. A response
//   seen with nothing outstanding leaves the count at 0 and pulses
//   underflow_o for that cycle.
//
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   clr_i        in   synchronous clear (has priority, suppresses underflow)
//   inc_i        in   req & gnt observed this cycle
//   dec_i        in   rvalid observed this cycle
//   cnt_o        out  current count (registered)
//   underflow_o  out  combinational underflow pulse for this cycle
// ----------------------------------------------------------------------------
module cgra_obi_outst_cnt #(
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CW        = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          underflow_o
);

    localparam logic [CW-1:0] MAX_VAL = CW'(MAX_OUTST);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next    = cnt_reg;
        underflow_o = 1'b0;
        if (clr_i) begin
            cnt_next = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_reg != MAX_VAL) begin
                cnt_next = cnt_reg + CW'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_reg == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_next = cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/cgra_power_ctrl.sv
// ----------------------------------------------------------------------------
// cgra_power_ctrl
//   Power-sequencing controller between the external-subsystem power manager
//   and the CGRA wrapper. Power-down: quiesce OBI masters, drain outstanding
//   transactions, gate the clock, then acknowledge the switch. Power-up:
//   drop the acknowledge, wait for the supply, re-enable the clock, and hold
//   the CGRA logic reset for a fixed number of cycles.
//
//   clk_i          in   system clock
//   rst_ni         in   asynchronous active-low reset
//   switch_off_i   in   power-off request (level)
//   switch_ack_o   out  high while the domain is safely off
//   iso_i          in   isolation; forces hold_req_o while ON
//   subsys_rst_ni  in   subsystem reset; forces RESET and clears counters
//   mst_req_i      in   OBI req per master
//   mst_gnt_i      in   OBI gnt per master
//   mst_rvalid_i   in   OBI rvalid per master
//   cgra_busy_i    in   CGRA executing a kernel
//   hold_req_o     out  masks new CGRA OBI requests
//   cgra_enable_o  out  CGRA clock-gate enable
//   cgra_rst_no    out  CGRA logic reset, active low
//   drain_err_o    out  sticky drain timeout / rvalid underflow
//
//   All delay parameters must be at least 1.
// ----------------------------------------------------------------------------
module cgra_power_ctrl
    import cgra_power_ctrl_pkg::*;
#(
    parameter int unsigned N_MASTER      = DEF_N_MASTER,
    parameter int unsigned MAX_OUTST     = DEF_MAX_OUTST,
    parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int unsigned ACK_DELAY     = DEF_ACK_DELAY,
    parameter int unsigned PWRUP_DELAY   = DEF_PWRUP_DELAY,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                switch_off_i,
    output logic                switch_ack_o,
    input  logic                iso_i,
    input  logic                subsys_rst_ni,
    input  logic [N_MASTER-1:0] mst_req_i,
    input  logic [N_MASTER-1:0] mst_gnt_i,
    input  logic [N_MASTER-1:0] mst_rvalid_i,
    input  logic                cgra_busy_i,
    output logic                hold_req_o,
    output logic                cgra_enable_o,
    output logic                cgra_rst_no,
    output logic                drain_err_o
);

    localparam int unsigned CW = outst_cnt_width(MAX_OUTST);
    localparam int unsigned TW = timer_width(DRAIN_TIMEOUT, ACK_DELAY, PWRUP_DELAY, RST_CYCLES);

    // Terminal timer values: the phase ends on the edge where the timer
    // already holds LAST, i.e. after exactly N cycles spent in the phase.
    localparam logic [TW-1:0] RST_LAST   = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_DELAY - 1);
    localparam logic [TW-1:0] PWRUP_LAST = TW'(PWRUP_DELAY - 1);

    // ------------------------------------------------------------------
    // Per-master outstanding-transaction counters
    // ------------------------------------------------------------------
    logic [N_MASTER-1:0][CW-1:0] outst_cnt;
    logic [N_MASTER-1:0]         outst_nz;
    logic [N_MASTER-1:0]         underflow;

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_outst
            cgra_obi_outst_cnt #(
                .MAX_OUTST (MAX_OUTST),
                .CW        (CW)
            ) u_cnt (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .clr_i       (!subsys_rst_ni),
                .inc_i       (mst_req_i[gi] & mst_gnt_i[gi]),
                .dec_i       (mst_rvalid_i[gi]),
                .cnt_o       (outst_cnt[gi]),
                .underflow_o (underflow[gi])
            );
            assign outst_nz[gi] = |outst_cnt[gi];
        end
    endgenerate

    // Idle uses the registered counts: a final rvalid is reflected one
    // cycle later, so gating never races a response still on the bus.
    logic drain_idle;
    assign drain_idle = !(|outst_nz) && !cgra_busy_i;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    pwr_state_e    state_reg, state_next;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic          timeout_set;
    pwr_out_t      out_reg, out_next;
    logic          drain_err_reg;

    // State register, phase timer, registered outputs and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= PWR_RESET;
            tmr_reg       <= '0;
            out_reg       <= OUT_RESET;
            drain_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tmr_reg       <= tmr_next;
            out_reg       <= out_next;
            drain_err_reg <= drain_err_reg | timeout_set | (|underflow);
        end
    end

    // Next-state logic. The timer restarts from 0 on every transition.
    always_comb begin
        state_next  = state_reg;
        tmr_next    = tmr_reg;
        timeout_set = 1'b0;
        if (!subsys_rst_ni) begin
            state_next = PWR_RESET;
            tmr_next   = '0;
        end else begin
            unique case (state_reg)
                PWR_RESET: begin
                    if (tmr_reg == RST_LAST) begin
                        state_next = PWR_ON;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + TW'(1);
                    end
                end
                PWR_ON: begin
                    if (switch_off_i) begin
                        state_next = PWR_DRAIN;
                        tmr_next   = '0;
                    end
                end
                PWR_DRAIN: begin
                    if (!switch_off_i) begin
                        state_next = PWR_ON;
                        tmr_next   = '0;
                    end else if (drain_idle) begin
                        state_next = PWR_GATE;
                        tmr_next   = '0;
                    end else if (tmr_reg == DRAIN_LAST) begin
                        state_next  = PWR_GATE;
                        tmr_next    = '0;
                        timeout_set = 1'b1;
                    end else begin
                        tmr_next = tmr_reg + TW'(1);
                    end
                end
                PWR_GATE: begin
                    // switch_off_i is deliberately ignored: always finish to OFF.
                    if (tmr_reg == ACK_LAST) begin
                        state_next = PWR_OFF;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + TW'(1);
                    end
                end
                PWR_OFF: begin
                    if (!switch_off_i) begin
                        state_next = PWR_WAKE;
                        tmr_next   = '0;
                    end
                end
                PWR_WAKE: begin
                    if (tmr_reg == PWRUP_LAST) begin
                        state_next = PWR_RESET;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr_reg + TW'(1);
                    end
                end
                default: begin
                    state_next = PWR_RESET;
                    tmr_next   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state; registering it makes each output
    // change on the same edge the state does.
    always_comb begin
        out_next = '{ack: 1'b0, hold: 1'b1, enable: 1'b0, rst_n: 1'b0};
        unique case (state_next)
            PWR_RESET: out_next = OUT_RESET;
            PWR_ON: begin
                out_next.hold   = iso_i;
                out_next.enable = 1'b1;
                out_next.rst_n  = 1'b1;
            end
            PWR_DRAIN: begin
                out_next.enable = 1'b1;
                out_next.rst_n  = 1'b1;
            end
            PWR_GATE: out_next.ack = 1'b0;
            PWR_OFF:  out_next.ack = 1'b1;
            PWR_WAKE: out_next.ack = 1'b0;
            default:  out_next = OUT_RESET;
        endcase
    end

    assign switch_ack_o  = out_reg.ack;
    assign hold_req_o    = out_reg.hold;
    assign cgra_enable_o = out_reg.enable;
    assign cgra_rst_no   = out_reg.rst_n;
    assign drain_err_o   = drain_err_reg;

endmodule

// File: tb/tb_cgra_power_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cgra_power_ctrl
//   Directed power sequences followed by a randomized run, all checked each
//   cycle against a phase/dwell-time reference model kept in this bench.
// ----------------------------------------------------------------------------
module tb_cgra_power_ctrl;

    localparam int N_MASTER      = 2;
    localparam int MAX_OUTST     = 4;
    localparam int DRAIN_TIMEOUT = 1024;
    localparam int ACK_DELAY     = 4;
    localparam int PWRUP_DELAY   = 8;
    localparam int RST_CYCLES    = 16;

    localparam int PH_RESET = 0;
    localparam int PH_ON    = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_GATE  = 3;
    localparam int PH_OFF   = 4;
    localparam int PH_WAKE  = 5;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b1;
    logic                switch_off = 1'b0;
    logic                iso = 1'b0;
    logic                subsys_rst_n = 1'b1;
    logic [N_MASTER-1:0] mst_req = '0;
    logic [N_MASTER-1:0] mst_gnt = '0;
    logic [N_MASTER-1:0] mst_rvalid = '0;
    logic                busy = 1'b0;
    logic                switch_ack_o, hold_req_o, cgra_enable_o, cgra_rst_no, drain_err_o;

    always #5 clk = ~clk;

    cgra_power_ctrl #(
        .N_MASTER      (N_MASTER),
        .MAX_OUTST     (MAX_OUTST),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .ACK_DELAY     (ACK_DELAY),
        .PWRUP_DELAY   (PWRUP_DELAY),
        .RST_CYCLES    (RST_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .switch_off_i  (switch_off),
        .switch_ack_o  (switch_ack_o),
        .iso_i         (iso),
        .subsys_rst_ni (subsys_rst_n),
        .mst_req_i     (mst_req),
        .mst_gnt_i     (mst_gnt),
        .mst_rvalid_i  (mst_rvalid),
        .cgra_busy_i   (busy),
        .hold_req_o    (hold_req_o),
        .cgra_enable_o (cgra_enable_o),
        .cgra_rst_no   (cgra_rst_no),
        .drain_err_o   (drain_err_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: current phase, cycles spent in it, outstanding counts.
    int m_phase;
    int m_dwell;
    int m_cnt [N_MASTER];
    bit m_err;
    bit e_ack, e_hold, e_en, e_rstn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_phase = PH_RESET;
        m_dwell = 0;
        m_err   = 1'b0;
        for (int i = 0; i < N_MASTER; i++) m_cnt[i] = 0;
        e_ack = 1'b0; e_hold = 1'b1; e_en = 1'b1; e_rstn = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        bit idle;
        int nph;
        idle = !busy;
        for (int i = 0; i < N_MASTER; i++) if (m_cnt[i] != 0) idle = 1'b0;
        nph = m_phase;
        if (!subsys_rst_n) begin
            nph     = PH_RESET;
            m_dwell = 0;
            for (int i = 0; i < N_MASTER; i++) m_cnt[i] = 0;
        end else begin
            case (m_phase)
                PH_RESET: begin
                    m_dwell++;
                    if (m_dwell == RST_CYCLES) nph = PH_ON;
                end
                PH_ON: if (switch_off) nph = PH_DRAIN;
                PH_DRAIN: begin
                    if (!switch_off) nph = PH_ON;
                    else if (idle) nph = PH_GATE;
                    else begin
                        m_dwell++;
                        if (m_dwell == DRAIN_TIMEOUT) begin
                            nph   = PH_GATE;
                            m_err = 1'b1;
                        end
                    end
                end
                PH_GATE: begin
                    m_dwell++;
                    if (m_dwell == ACK_DELAY) nph = PH_OFF;
                end
                PH_OFF: if (!switch_off) nph = PH_WAKE;
                default: begin
                    m_dwell++;
                    if (m_dwell == PWRUP_DELAY) nph = PH_RESET;
                end
            endcase
            for (int i = 0; i < N_MASTER; i++) begin
                bit inc, dec;
                inc = mst_req[i] & mst_gnt[i];
                dec = mst_rvalid[i];
                if (inc && !dec) begin
                    if (m_cnt[i] < MAX_OUTST) m_cnt[i]++;
                end else if (dec && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else m_cnt[i]--;
                end
            end
        end
        if (nph != m_phase) m_dwell = 0;
        m_phase = nph;
        e_ack  = (m_phase == PH_OFF);
        e_en   = (m_phase == PH_RESET) || (m_phase == PH_ON) || (m_phase == PH_DRAIN);
        e_rstn = (m_phase == PH_ON) || (m_phase == PH_DRAIN);
        e_hold = (m_phase == PH_ON) ? iso : 1'b1;
    endtask

    task automatic check_model();
        chk("ack", switch_ack_o, e_ack);
        chk("hold", hold_req_o, e_hold);
        chk("enable", cgra_enable_o, e_en);
        chk("rst_n", cgra_rst_no, e_rstn);
        chk("drain_err", drain_err_o, m_err);
        for (int i = 0; i < N_MASTER; i++)
            chk($sformatf("cnt%0d", i), 32'(dut.outst_cnt[i]), 32'(m_cnt[i]));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int t_a, t_b, t_c;
        model_init();

        // ---- asynchronous reset ----
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", switch_ack_o, 1'b0);
        chk("rst_hold", hold_req_o, 1'b1);
        chk("rst_enable", cgra_enable_o, 1'b1);
        chk("rst_rst_n", cgra_rst_no, 1'b0);
        chk("rst_err", drain_err_o, 1'b0);
        chk("rst_cnt0", 32'(dut.outst_cnt[0]), 32'd0);
        rst_ni = 1'b1;
        t_a = -1;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (t_a < 0 && cgra_rst_no) t_a = t;
        end
        chk("rst_release_cycles", t_a, 16);

        // ---- idle power-down / power-up ----
        switch_off = 1'b1;
        t_a = -1; t_b = -1; t_c = -1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t_a < 0 && hold_req_o) t_a = t;
            if (t_b < 0 && !cgra_enable_o) t_b = t;
            if (t_c < 0 && switch_ack_o) t_c = t;
        end
        chk("off_hold_at", t_a, 1);
        chk("off_enable_at", t_b, 2);
        chk("off_ack_at", t_c, 6);
        switch_off = 1'b0;
        t_a = -1; t_b = -1; t_c = -1;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (t_a < 0 && !switch_ack_o) t_a = t;
            if (t_b < 0 && cgra_enable_o) t_b = t;
            if (t_c < 0 && cgra_rst_no) t_c = t;
        end
        chk("on_ack_low_at", t_a, 1);
        chk("on_enable_at", t_b, 9);
        chk("on_rst_n_at", t_c, 25);

        // ---- drain of 3 outstanding on master 0 ----
        mst_req[0] = 1'b1; mst_gnt[0] = 1'b1;
        steps(3);
        mst_req[0] = 1'b0; mst_gnt[0] = 1'b0;
        chk("m0_outst3", 32'(dut.outst_cnt[0]), 32'd3);
        switch_off = 1'b1;
        steps(2);
        for (int k = 0; k < 3; k++) begin
            mst_rvalid[0] = 1'b1;
            step();
            mst_rvalid[0] = 1'b0;
            if (k < 2) begin
                steps(4);
            end else begin
                chk("drain_en_after_last_rvalid", cgra_enable_o, 1'b1);
                step();
                chk("drain_en_gated", cgra_enable_o, 1'b0);
            end
        end
        chk("drain_no_err", drain_err_o, 1'b0);
        steps(8);
        switch_off = 1'b0;
        steps(30);

        // ---- same-cycle inc/dec and underflow on master 1 ----
        mst_req[1] = 1'b1; mst_gnt[1] = 1'b1;
        step();
        chk("m1_cnt1", 32'(dut.outst_cnt[1]), 32'd1);
        mst_rvalid[1] = 1'b1;
        step();
        chk("m1_same_cycle", 32'(dut.outst_cnt[1]), 32'd1);
        mst_req[1] = 1'b0; mst_gnt[1] = 1'b0;
        step();
        chk("m1_cnt0", 32'(dut.outst_cnt[1]), 32'd0);
        step();
        mst_rvalid[1] = 1'b0;
        chk("m1_underflow_cnt", 32'(dut.outst_cnt[1]), 32'd0);
        chk("m1_underflow_err", drain_err_o, 1'b1);

        // ---- rst_ni clears the sticky error ----
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        model_init();
        chk("rst2_err", drain_err_o, 1'b0);
        rst_ni = 1'b1;
        steps(20);

        // ---- drain timeout with busy CGRA ----
        busy = 1'b1;
        switch_off = 1'b1;
        t_a = -1;
        for (int t = 1; t <= 1100; t++) begin
            step();
            if (cgra_enable_o == 1'b0) begin
                t_a = t;
                break;
            end
        end
        chk("timeout_gate_at", t_a, 1 + DRAIN_TIMEOUT);
        chk("timeout_err", drain_err_o, 1'b1);
        steps(6);
        switch_off = 1'b0;
        busy = 1'b0;
        steps(30);
        chk("err_persists", drain_err_o, 1'b1);
        chk("err_persist_rst_n", cgra_rst_no, 1'b1);

        // ---- subsystem reset during DRAIN ----
        mst_req[1] = 1'b1; mst_gnt[1] = 1'b1;
        steps(2);
        mst_req[1] = 1'b0; mst_gnt[1] = 1'b0;
        busy = 1'b1;
        switch_off = 1'b1;
        steps(3);
        subsys_rst_n = 1'b0;
        step();
        chk("sub_hold", hold_req_o, 1'b1);
        chk("sub_rst_n", cgra_rst_no, 1'b0);
        chk("sub_enable", cgra_enable_o, 1'b1);
        chk("sub_cnt1", 32'(dut.outst_cnt[1]), 32'd0);
        subsys_rst_n = 1'b1;
        switch_off = 1'b0;
        busy = 1'b0;
        steps(20);

        // ---- randomized run ----
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) switch_off = ~switch_off;
            iso  = ($urandom_range(0, 3) == 0);
            busy = ($urandom_range(0, 7) == 0);
            subsys_rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N_MASTER; i++) begin
                mst_req[i] = $urandom_range(0, 1);
                mst_gnt[i] = $urandom_range(0, 1);
                if (m_cnt[i] > 0) mst_rvalid[i] = $urandom_range(0, 1);
                else mst_rvalid[i] = ($urandom_range(0, 199) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
